// File: rtl/o_serializer.sv
// Parallel-to-serial output stage: holding register feeding a shift register,
// one bit per clock onto Q, idle level between streams, underrun flag on run-dry.
module o_serializer #(
  parameter int    WIDTH      = 4,
  parameter string BIT_ORDER  = "LSB_FIRST",
  parameter logic  IDLE_VALUE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             DATA_VALID,
  output logic             READY,
  output logic             Q,
  output logic             ACTIVE,
  output logic             UNDERRUN
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam bit MSB_OUT = (BIT_ORDER == "MSB_FIRST");

  if (WIDTH < 2 || WIDTH > 10) begin : g_bad_width
    $error("o_serializer: WIDTH=%0d outside legal range 2..10", WIDTH);
  end
  if (BIT_ORDER != "LSB_FIRST" && BIT_ORDER != "MSB_FIRST") begin : g_bad_order
    $error("o_serializer: BIT_ORDER must be LSB_FIRST or MSB_FIRST");
  end

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_data_reg, hold_data_next;
  logic             hold_full_reg, hold_full_next;
  logic [WIDTH-1:0] sh_data_reg, sh_data_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             ready_reg, ready_next;
  logic             q_reg, q_next;
  logic             active_reg, active_next;
  logic             underrun_reg, underrun_next;
  logic [WIDTH-1:0] sh_shifted;
  logic             accept;

  // Shift moves the next bit toward whichever end drives Q.
  if (MSB_OUT) begin : g_msb
    assign sh_shifted = {sh_data_reg[WIDTH-2:0], 1'b0};
  end else begin : g_lsb
    assign sh_shifted = {1'b0, sh_data_reg[WIDTH-1:1]};
  end

  assign accept = DATA_VALID && ready_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= S_IDLE;
      hold_data_reg <= '0;
      hold_full_reg <= 1'b0;
      sh_data_reg   <= '0;
      cnt_reg       <= '0;
      ready_reg     <= 1'b0;
      q_reg         <= IDLE_VALUE;
      active_reg    <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_data_reg <= hold_data_next;
      hold_full_reg <= hold_full_next;
      sh_data_reg   <= sh_data_next;
      cnt_reg       <= cnt_next;
      ready_reg     <= ready_next;
      q_reg         <= q_next;
      active_reg    <= active_next;
      underrun_reg  <= underrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_data_next = hold_data_reg;
    hold_full_next = hold_full_reg;
    sh_data_next   = sh_data_reg;
    cnt_next       = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (hold_full_reg) begin
          sh_data_next   = hold_data_reg;
          hold_full_next = 1'b0;
          cnt_next       = '0;
          state_next     = S_SHIFT;
        end
      end
      default: begin
        if (cnt_reg == LAST) begin
          if (hold_full_reg) begin
            sh_data_next   = hold_data_reg;
            hold_full_next = 1'b0;
            cnt_next       = '0;
          end else begin
            cnt_next   = '0;
            state_next = S_IDLE;
          end
        end else begin
          sh_data_next = sh_shifted;
          cnt_next     = cnt_reg + CW'(1);
        end
      end
    endcase

    // READY low whenever hold is full, so accept never coincides with a load.
    if (accept) begin
      hold_data_next = D;
      hold_full_next = 1'b1;
    end
  end

  // Outputs are precomputed from next state so Q/ACTIVE/READY come straight from flops.
  always_comb begin
    ready_next    = !hold_full_next;
    active_next   = (state_next == S_SHIFT);
    underrun_next = (state_reg == S_SHIFT) && (state_next == S_IDLE);
    q_next        = IDLE_VALUE;
    if (state_next == S_SHIFT) begin
      q_next = MSB_OUT ? sh_data_next[WIDTH-1] : sh_data_next[0];
    end
  end

  assign READY    = ready_reg;
  assign Q        = q_reg;
  assign ACTIVE   = active_reg;
  assign UNDERRUN = underrun_reg;

endmodule

// File: tb/tb_o_serializer.sv
// Randomized and directed bench for o_serializer: an LSB-first and an MSB-first
// instance share stimulus and are checked each cycle against a word-schedule model.
module tb_o_serializer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] d = '0;
  logic dv = 1'b0;
  logic ready_a, q_a, act_a, und_a;
  logic ready_b, q_b, act_b, und_b;

  always #5 clk = ~clk;

  o_serializer #(.WIDTH(W), .BIT_ORDER("LSB_FIRST"), .IDLE_VALUE(1'b0)) dut_a (
    .CLK(clk), .RST(rst_n), .D(d), .DATA_VALID(dv),
    .READY(ready_a), .Q(q_a), .ACTIVE(act_a), .UNDERRUN(und_a));

  o_serializer #(.WIDTH(W), .BIT_ORDER("MSB_FIRST"), .IDLE_VALUE(1'b1)) dut_b (
    .CLK(clk), .RST(rst_n), .D(d), .DATA_VALID(dv),
    .READY(ready_b), .Q(q_b), .ACTIVE(act_b), .UNDERRUN(und_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: each accepted word is scheduled to start at max(accept+1, previous start+W);
  // outputs after edge e follow from which scheduled word covers e.
  typedef struct {
    int acc;
    int start;
    logic [W-1:0] w;
  } rec_t;
  rec_t sched[$];
  int cyc = 0;
  int last_start = -100;
  logic exp_q_a = 1'b0, exp_q_b = 1'b1, exp_act = 1'b0, exp_und = 1'b0, exp_ready = 1'b0;

  always @(posedge clk) begin : model
    int e, st, i;
    bit ended, began;
    if (!rst_n) begin
      sched.delete();
      cyc = 0;
      last_start = -100;
      exp_q_a = 1'b0; exp_q_b = 1'b1; exp_act = 1'b0; exp_und = 1'b0; exp_ready = 1'b0;
    end else begin
      e = cyc;
      cyc++;
      if (dv && exp_ready) begin
        st = (e + 1 > last_start + W) ? e + 1 : last_start + W;
        sched.push_back('{acc: e, start: st, w: d});
        last_start = st;
      end
      exp_q_a = 1'b0; exp_q_b = 1'b1; exp_act = 1'b0; exp_ready = 1'b1;
      ended = 1'b0; began = 1'b0;
      foreach (sched[k]) begin
        if (sched[k].start <= e && e < sched[k].start + W) begin
          i = e - sched[k].start;
          exp_q_a = sched[k].w[i];
          exp_q_b = sched[k].w[W-1-i];
          exp_act = 1'b1;
        end
        if (sched[k].start + W == e) ended = 1'b1;
        if (sched[k].start == e) began = 1'b1;
        if (sched[k].acc <= e && e < sched[k].start) exp_ready = 1'b0;
      end
      exp_und = ended && !began;
      while (sched.size() > 0 && sched[0].start + W < e) void'(sched.pop_front());
    end
  end

  always @(negedge clk) begin : compare
    if (!rst_n) begin
      check("rst_q_a", q_a, 1'b0);
      check("rst_q_b", q_b, 1'b1);
      check("rst_ready_a", ready_a, 1'b0);
      check("rst_ready_b", ready_b, 1'b0);
      check("rst_active_a", act_a, 1'b0);
      check("rst_active_b", act_b, 1'b0);
      check("rst_underrun_a", und_a, 1'b0);
      check("rst_underrun_b", und_b, 1'b0);
    end else begin
      check("q_a", q_a, exp_q_a);
      check("q_b", q_b, exp_q_b);
      check("ready_a", ready_a, exp_ready);
      check("ready_b", ready_b, exp_ready);
      check("active_a", act_a, exp_act);
      check("active_b", act_b, exp_act);
      check("underrun_a", und_a, exp_und);
      check("underrun_b", und_b, exp_und);
    end
  end

  // Recorder for the directed literal checks.
  bit rec_en = 1'b0;
  logic rec_qa[$], rec_qb[$], rec_act[$], rec_ua[$];
  int rec_und = 0;

  always @(negedge clk) begin
    if (rec_en) begin
      rec_qa.push_back(q_a);
      rec_qb.push_back(q_b);
      rec_act.push_back(act_b);
      rec_ua.push_back(und_a);
      if (und_b) rec_und++;
    end
  end

  task automatic rec_clear();
    rec_qa.delete(); rec_qb.delete(); rec_act.delete(); rec_ua.delete();
    rec_und = 0;
  endtask

  // Present w until accepted; with noise, D keeps changing while READY is low.
  task automatic send(input logic [W-1:0] w, input bit noise);
    int n;
    logic rdy;
    n = 0;
    d = w;
    dv = 1'b1;
    forever begin
      @(negedge clk);
      rdy = ready_a;
      @(posedge clk);
      #1;
      if (rdy) break;
      if (noise) d = W'($urandom);
      n++;
      if (n > 50) begin
        check("send_ready_wait", rdy, 1'b1);
        break;
      end
    end
    dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int first, last, cnt;
    logic [11:0] stream;
    int probs[6] = '{90, 30, 100, 60, 10, 75};

    // Reset with valid data presented; nothing may be captured.
    d = W'($urandom);
    dv = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_release", ready_a, 1'b1);
    dv = 1'b0;
    idle(3);

    // Single word 1101.
    send(4'b1101, 1'b0);
    rec_clear();
    rec_en = 1'b1;
    idle(7);
    rec_en = 1'b0;
    check("single_lsb_seq", {rec_qa[1], rec_qa[2], rec_qa[3], rec_qa[4]}, 4'b1011);
    check("single_msb_seq", {rec_qb[1], rec_qb[2], rec_qb[3], rec_qb[4]}, 4'b1101);
    check("single_idle_before", rec_qa[0], 1'b0);
    check("single_idle_after", rec_qa[5], 1'b0);
    check("single_underrun_at_k5", rec_ua[5], 1'b1);
    check("single_underrun_count", rec_und, 1);
    idle(3);

    // Back-to-back A, 5, F.
    rec_clear();
    rec_en = 1'b1;
    send(4'hA, 1'b0);
    send(4'h5, 1'b0);
    send(4'hF, 1'b0);
    idle(8);
    rec_en = 1'b0;
    first = -1; last = -1; cnt = 0; stream = '0;
    foreach (rec_act[k]) begin
      if (rec_act[k]) begin
        if (first < 0) first = k;
        last = k;
        cnt++;
        stream = {stream[10:0], rec_qb[k]};
      end
    end
    check("b2b_active_cycles", cnt, 12);
    check("b2b_gapless_span", last - first, 11);
    check("b2b_msb_stream", stream, 12'b1010_0101_1111);
    check("b2b_underrun_count", rec_und, 1);
    idle(3);

    // Backpressure with D changing while READY is low.
    rec_clear();
    rec_en = 1'b1;
    for (int k = 0; k < 6; k++) send(W'($urandom), 1'b1);
    idle(10);
    rec_en = 1'b0;
    cnt = 0;
    foreach (rec_act[k]) if (rec_act[k]) cnt++;
    check("bp_active_cycles", cnt, 6 * W);
    check("bp_underrun_count", rec_und, 1);

    // Reset mid-word with hold full.
    send(4'hF, 1'b0);
    send(4'hF, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_q_a", q_a, 1'b0);
    check("midrst_q_b", q_b, 1'b1);
    check("midrst_active", act_a, 1'b0);
    idle(2);
    rst_n = 1'b1;
    rec_clear();
    rec_en = 1'b1;
    idle(12);
    rec_en = 1'b0;
    cnt = 0;
    foreach (rec_act[k]) if (rec_act[k]) cnt++;
    check("midrst_no_reappear", cnt, 0);
    check("midrst_no_underrun", rec_und, 0);

    // Randomized phases of varying offered load.
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 100; k++) begin
        dv = ($urandom_range(0, 99) < probs[p]);
        d = W'($urandom);
        idle(1);
      end
    end
    dv = 1'b0;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
